// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings for the multicycle RV32I control path
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_ALU_WB  = 4'd7,
    S_EXEC_I  = 4'd8,
    S_JAL     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JALR    = 4'd11,
    S_LUI     = 4'd12,
    S_AUIPC   = 4'd13,
    S_TRAP    = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] A_PC      = 2'b00;
  localparam logic [1:0] A_OLD_PC  = 2'b01;
  localparam logic [1:0] A_RS1     = 2'b10;
  localparam logic [1:0] A_ZERO    = 2'b11;
  localparam logic [1:0] B_RS2     = 2'b00;
  localparam logic [1:0] B_IMM     = 2'b01;
  localparam logic [1:0] B_FOUR    = 2'b10;
  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - funct3/funct7 to ALU operation for R- and I-type instructions
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // SUB exists only for R-type; ADDI ignores funct7[5].
      3'b000: alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_control = ALU_SLL;
      3'b010: alu_control = ALU_SLT;
      3'b011: alu_control = ALU_SLTU;
      3'b100: alu_control = ALU_XOR;
      3'b101: alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_control = ALU_OR;
      3'b111: alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// rtl/multicycle_ctrl_v2.sv - multicycle RV32I control FSM with memory wait states and illegal trap
module multicycle_ctrl_v2
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W   = 4,
  parameter int STATE_W      = 4,
  parameter int TRAP_ILLEGAL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  mem_ready,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic                  adr_src,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal,
  output logic [STATE_W-1:0]    current_state
);

  state_t     state, next_state;
  logic       illegal_q;
  logic       take;
  logic [3:0] dec_alu, alu_code;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7_5    (funct7[5]),
    .is_rtype    (state == S_EXEC_R),
    .alu_control (dec_alu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    take = 1'b0;
    case (funct3)
      3'b000: take = alu_zero;
      3'b001: take = !alu_zero;
      3'b100: take = alu_lt;
      3'b101: take = !alu_lt;
      3'b110: take = alu_ltu;
      3'b111: take = !alu_ltu;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALU_OUT;
    alu_src_a  = A_PC;
    alu_src_b  = B_RS2;
    alu_code   = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = B_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = A_OLD_PC;
        alu_src_b = B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
          OP_R:      next_state = S_EXEC_R;
          OP_I:      next_state = S_EXEC_I;
          OP_BRANCH: next_state = S_BRANCH;
          OP_JAL:    next_state = S_JAL;
          OP_JALR:   next_state = S_JALR;
          OP_LUI:    next_state = S_LUI;
          OP_AUIPC:  next_state = S_AUIPC;
          default:   next_state = (TRAP_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        // A non-memory opcode here means the IR changed under us; drop the instruction.
        if (opcode == OP_LOAD)       next_state = S_MEM_RD;
        else if (opcode == OP_STORE) next_state = S_MEM_WR;
        else                         next_state = S_FETCH;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_MEM_WB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = A_RS1;
        alu_src_b  = B_RS2;
        alu_code   = dec_alu;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = A_RS1;
        alu_src_b  = B_IMM;
        alu_code   = dec_alu;
        next_state = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_a  = A_ZERO;
        alu_src_b  = B_IMM;
        next_state = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a  = A_OLD_PC;
        alu_src_b  = B_IMM;
        next_state = S_ALU_WB;
      end
      S_JALR: begin
        alu_src_a  = A_RS1;
        alu_src_b  = B_IMM;
        next_state = S_JAL;
      end
      S_JAL: begin
        alu_src_a  = A_OLD_PC;
        alu_src_b  = B_FOUR;
        pc_write   = 1'b1;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = A_RS1;
        alu_src_b  = B_RS2;
        alu_code   = ALU_SUB;
        pc_write   = take;
        next_state = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
    // Hold every output at its idle value while reset is asserted.
    if (reset) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      adr_src    = 1'b0;
      result_src = RES_ALU_OUT;
      alu_src_a  = A_PC;
      alu_src_b  = B_RS2;
      alu_code   = ALU_ADD;
    end
  end

  assign alu_control   = ALU_CTRL_W'(alu_code);
  assign current_state = STATE_W'(state);
  assign illegal       = illegal_q;

endmodule
